// File: rtl/ram_param_clr.sv
// Single-port synchronous RAM with registered read and a hardware clear engine
// that sweeps every word to CLR_VAL after reset or on a clear request.
module ram_param_clr #(
    parameter int               WIDTH   = 16,
    parameter int               ADDR_W  = 12,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [WIDTH-1:0]  in,
    input  logic              load,
    input  logic              clear,
    output logic [WIDTH-1:0]  out,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = '1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [WIDTH-1:0]  mem_wd;
    logic [WIDTH-1:0]  mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // The last word is detected before the increment, so ptr never needs a wrap bit.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        case (state)
            IDLE: begin
                if (clear) begin
                    state_nx = CLEAR;
                    ptr_nx   = '0;
                end
            end
            CLEAR: begin
                ptr_nx = ptr + 1'b1;
                if (ptr == LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == CLEAR);
        mem_we = 1'b0;
        mem_wa = address;
        mem_wd = in;
        if (!reset) begin
            case (state)
                CLEAR: begin
                    mem_we = 1'b1;
                    mem_wa = ptr;
                    mem_wd = CLR_VAL;
                end
                IDLE:    mem_we = load && !clear;
                default: mem_we = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    // Read-first: the read samples the array before this edge's write lands.
    always_ff @(posedge clk) begin
        if (reset || state == CLEAR) out <= CLR_VAL;
        else                         out <= mem[address];
    end

endmodule

// File: tb/tb_ram_param_clr.sv
// Bench for ram_param_clr: a word-level model checked every cycle, plus
// directed reads with hand-computed expectations.
module tb_ram_param_clr;

    localparam int W = 16, AW = 4, DEPTH = 16, AW2 = 3, DEPTH2 = 8;
    localparam logic [W-1:0] CLR = 16'h0000, CLR2 = 16'hA5A5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, load, clear, busy;
    logic [AW-1:0]  address;
    logic [W-1:0]   din, dout;
    logic           reset2, load2, clear2, busy2;
    logic [AW2-1:0] address2;
    logic [W-1:0]   din2, dout2;

    ram_param_clr #(.WIDTH(W), .ADDR_W(AW), .CLR_VAL(CLR)) dut (
        .clk(clk), .reset(reset), .address(address), .in(din), .load(load),
        .clear(clear), .out(dout), .busy(busy));

    ram_param_clr #(.WIDTH(W), .ADDR_W(AW2), .CLR_VAL(CLR2)) dut2 (
        .clk(clk), .reset(reset2), .address(address2), .in(din2), .load(load2),
        .clear(clear2), .out(dout2), .busy(busy2));

    int checks = 0, errors = 0;

    // Model: a sweep is an opaque busy window of DEPTH cycles after which the
    // whole memory holds the clear value; inputs are ignored while it runs.
    logic [W-1:0] mmem [DEPTH];
    logic [W-1:0] exp_out;
    int  left = 0, left2 = 0;
    bit  mvalid = 0, mvalid2 = 0;

    always @(posedge clk) begin
        if (reset) begin
            left    <= DEPTH;
            exp_out <= CLR;
            for (int i = 0; i < DEPTH; i++) mmem[i] <= CLR;
            mvalid  <= 1'b1;
        end else if (left > 0) begin
            left    <= left - 1;
            exp_out <= CLR;
        end else begin
            exp_out <= mmem[address];
            if (clear) begin
                left <= DEPTH;
                for (int i = 0; i < DEPTH; i++) mmem[i] <= CLR;
            end else if (load) begin
                mmem[address] <= din;
            end
        end
        if (reset2) begin
            left2   <= DEPTH2;
            mvalid2 <= 1'b1;
        end else if (left2 > 0) begin
            left2 <= left2 - 1;
        end
    end

    bit          lit_en = 0;
    int          lit_sel = 0;
    logic [W-1:0] lit_exp = '0, lit_act = '0;
    string       lit_name = "";

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mvalid) begin
            chk("busy", W'(busy), W'(left > 0));
            chk("out", dout, exp_out);
        end
        if (mvalid2) begin
            chk("busy2", W'(busy2), W'(left2 > 0));
            if (left2 > 0) chk("out2_busy", dout2, CLR2);
        end
        if (lit_en) begin
            case (lit_sel)
                0:       chk(lit_name, dout, lit_exp);
                1:       chk(lit_name, dout2, lit_exp);
                default: chk(lit_name, lit_act, lit_exp);
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        lit_en = 1'b0;
    endtask

    task automatic lit(input string name, input int sel, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        lit_name = name; lit_sel = sel; lit_act = act; lit_exp = exp; lit_en = 1'b1;
        step();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d);
        address = a; din = d; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic rd(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        address = a;
        step();
        lit(name, 0, '0, exp);
    endtask

    task automatic rd2(input logic [AW2-1:0] a, input logic [W-1:0] exp);
        address2 = a;
        step();
        lit("rd2", 1, '0, exp);
    endtask

    int n, n2;

    initial begin
        reset = 1'b1; load = 1'b0; clear = 1'b0; address = '0; din = '0;
        reset2 = 1'b1; load2 = 1'b0; clear2 = 1'b0; address2 = '0; din2 = '0;
        step();
        reset = 1'b0; reset2 = 1'b0;

        // Reset sweep length on both instances
        n = 0; n2 = 0;
        while ((busy || busy2) && n < 100) begin
            if (busy)  n++;
            if (busy2) n2++;
            step();
        end
        lit("reset_busy_len", 2, W'(n), 16'd16);
        lit("reset_busy_len2", 2, W'(n2), 16'd8);
        for (int i = 0; i < DEPTH; i++) rd("rd_after_reset", AW'(i), 16'h0000);
        for (int i = 0; i < DEPTH2; i++) rd2(AW2'(i), 16'hA5A5);

        // Idle write/read
        wr(4'd3, 16'hBEEF);
        wr(4'd15, 16'h1234);
        rd("rd3", 4'd3, 16'hBEEF);
        rd("rd15", 4'd15, 16'h1234);
        rd("rd4", 4'd4, 16'h0000);

        // Read-first on same address
        wr(4'd5, 16'hAAAA);
        address = 4'd5; din = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        lit("read_first_old", 0, '0, 16'hAAAA);
        rd("read_first_new", 4'd5, 16'h5555);

        // Fill, clear, and a dropped write during the sweep
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), 16'hFFFF);
        rd("rd_fill", 4'd9, 16'hFFFF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            if (n == 2) begin address = 4'd2; din = 16'h7777; load = 1'b1; end
            else load = 1'b0;
            step();
        end
        load = 1'b0;
        lit("clear_busy_len", 2, W'(n), 16'd16);
        for (int i = 0; i < DEPTH; i++) rd("rd_after_clear", AW'(i), 16'h0000);

        // Reset mid-sweep restarts it; clear pulses do not extend it
        wr(4'd6, 16'h1111);
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (7) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            clear = (n == 3 || n == 10);
            step();
        end
        clear = 1'b0;
        lit("restart_busy_len", 2, W'(n), 16'd16);
        rd("rd6_after_restart", 4'd6, 16'h0000);
        wr(4'd6, 16'h2222);
        rd("rd6_post", 4'd6, 16'h2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
